// File: rtl/adc_serial_emulator.sv
//------------------------------------------------------------------------------
// adc_serial_emulator: SAR ADC emulator with BUSY-timed conversion and serial readout
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adc_serial_emulator #(
  parameter int NBITS       = 18,
  parameter int CONV_CYCLES = 40,
  parameter int SCLK_DIV    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_i,
  input  logic             cnvst_i,
  input  logic             mode_i,
  input  logic [NBITS-1:0] sample_i,
  input  logic             clr_ovr_i,
  output logic             busy_o,
  output logic             sclk_o,
  output logic             sync_o,
  output logic             sdout_o,
  output logic             done_o,
  output logic             overrun_o
);

  localparam int              HW          = $clog2(2 * NBITS);
  localparam logic [1:0]      S_IDLE      = 2'd0;
  localparam logic [1:0]      S_CONV      = 2'd1;
  localparam logic [1:0]      S_SHIFT     = 2'd2;
  localparam logic [9:0]      C_CONV_LAST = 10'(CONV_CYCLES - 1);
  localparam logic [7:0]      C_DIV_LAST  = 8'(SCLK_DIV - 1);
  localparam logic [HW-1:0]   C_HALF_LAST = HW'(2 * NBITS - 1);

  logic [1:0]       state_q, state_d;
  logic             cnvst_q, arm_q;
  logic [9:0]       cnt_q, cnt_d;
  logic [7:0]       div_q, div_d;
  logic [HW-1:0]    half_q, half_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [NBITS-1:0] ramp_q, ramp_d;
  logic             busy_q, busy_d, sclk_q, sclk_d, sync_q, sync_d;
  logic             sdout_q, sdout_d, done_q, done_d, ovr_q, ovr_d;
  logic             w_edge, w_last;

  // arm_q keeps the reset value of cnvst_q from counting as a real high sample
  assign w_edge = cnvst_q & arm_q & ~cnvst_i;
  assign w_last = (div_q == C_DIV_LAST) && (half_q == C_HALF_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnvst_q <= 1'b1;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      half_q  <= '0;
      sh_q    <= '0;
      ramp_q  <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sync_q  <= 1'b0;
      sdout_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnvst_q <= cnvst_i;
      arm_q   <= arm_q | cnvst_i;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sh_q    <= sh_d;
      ramp_q  <= ramp_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      sdout_q <= sdout_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // The DONE cycle is already IDLE but must still reject a new request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_edge && !cs_i && !done_q) state_d = S_CONV;
      S_CONV:  if (cs_i) state_d = S_IDLE;
               else if (cnt_q == C_CONV_LAST) state_d = S_SHIFT;
      S_SHIFT: if (cs_i || w_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    half_d  = half_q;
    sh_d    = sh_q;
    ramp_d  = ramp_q;
    busy_d  = 1'b0;
    sclk_d  = 1'b0;
    sync_d  = 1'b0;
    sdout_d = 1'b0;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (w_edge && (state_q != S_IDLE || done_q)) ovr_d = 1'b1;
    else if (clr_ovr_i) ovr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_CONV) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          sh_d   = mode_i ? ramp_q : sample_i;
        end
      end
      S_CONV: begin
        if (state_d == S_CONV) begin
          busy_d = 1'b1;
          cnt_d  = cnt_q + 10'd1;
        end else if (state_d == S_SHIFT) begin
          sync_d  = 1'b1;
          sdout_d = sh_q[NBITS-1];
          sh_d    = sh_q << 1;
          div_d   = '0;
          half_d  = '0;
        end
      end
      S_SHIFT: begin
        if (state_d == S_SHIFT) begin
          sync_d  = 1'b1;
          sclk_d  = sclk_q;
          sdout_d = sdout_q;
          if (div_q == C_DIV_LAST) begin
            div_d  = '0;
            half_d = half_q + HW'(1);
            sclk_d = ~sclk_q;
            // new data bit only on the SCLK falling edge
            if (sclk_q) begin
              sdout_d = sh_q[NBITS-1];
              sh_d    = sh_q << 1;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end else if (!cs_i) begin
          done_d = 1'b1;
          ramp_d = ramp_q + NBITS'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy_o    = busy_q;
  assign sclk_o    = sclk_q;
  assign sync_o    = sync_q;
  assign sdout_o   = sdout_q;
  assign done_o    = done_q;
  assign overrun_o = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_emulator.sv
//------------------------------------------------------------------------------
// tb_adc_serial_emulator: three parameter sets checked against a timeline model
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adc_serial_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_fin  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int NB = (gi == 2) ? 4 : 18;
    localparam int CV = (gi == 0) ? 40 : 1;
    localparam int DV = (gi == 0) ? 2 : 1;
    localparam int SH = 2 * NB * DV;
    localparam int L  = CV + 1 + SH;

    logic rst = 1'b1, cs = 1'b0, cnvst = 1'b1, mode = 1'b0, clr = 1'b0;
    logic [NB-1:0] sample = '0;
    logic busy, sclk, sync, sdout, done, ovr;

    adc_serial_emulator #(.NBITS(NB), .CONV_CYCLES(CV), .SCLK_DIV(DV)) u_dut (
      .clk_i(clk), .rst_i(rst), .cs_i(cs), .cnvst_i(cnvst), .mode_i(mode),
      .sample_i(sample), .clr_ovr_i(clr), .busy_o(busy), .sclk_o(sclk),
      .sync_o(sync), .sdout_o(sdout), .done_o(done), .overrun_o(ovr)
    );

    // Model: a frame is a timeline indexed by cycles since acceptance (1..L)
    bit m_valid = 1'b0, m_act = 1'b0, m_prev = 1'b0, m_ovr = 1'b0;
    int m_pos = 0;
    logic [NB-1:0] m_word = '0, m_ramp = '0;

    always @(posedge clk) begin : p_model
      bit e;
      bit was;
      if (rst) begin
        m_valid = 1'b1; m_act = 1'b0; m_prev = 1'b0; m_ovr = 1'b0; m_ramp = '0;
      end else if (m_valid) begin
        e = m_prev && !cnvst;
        m_prev = cnvst;
        was = m_act;
        if (e && was) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (was) begin
          if (m_pos == L || cs) m_act = 1'b0;
          else begin
            m_pos++;
            if (m_pos == L) m_ramp = m_ramp + 1'b1;
          end
        end else if (e && !cs) begin
          m_act = 1'b1; m_pos = 1; m_word = mode ? m_ramp : sample;
        end
      end
    end

    always @(negedge clk) begin : p_cmp
      logic [5:0] exp_v;
      int k;
      exp_v = {5'b0, m_ovr};
      if (m_valid) begin
        if (m_act) begin
          k = m_pos - CV - 1;
          if (m_pos <= CV) exp_v[5] = 1'b1;
          if (k >= 0 && k < SH) begin
            exp_v[4] = ((k / DV) % 2) == 1;
            exp_v[3] = 1'b1;
            exp_v[2] = m_word[NB - 1 - k / (2 * DV)];
          end
          exp_v[1] = (m_pos == L);
        end
        chk("outputs{busy,sclk,sync,sdout,done,ovr}",
            longint'({busy, sclk, sync, sdout, done, ovr}), longint'(exp_v));
      end
    end

    // Independent capture of what a receiver sees on SCLK rising edges
    logic sclk_p = 1'b0, busy_p = 1'b0;
    int nb = 0, ns = 0;
    logic [NB-1:0] cap = '0;
    logic [NB-1:0] words[$];
    int busyc[$];
    int syncc[$];

    always @(negedge clk) begin : p_cap
      if (m_valid) begin
        if (busy && !busy_p) begin nb = 0; ns = 0; cap = '0; end
        if (busy) nb++;
        if (sync) ns++;
        if (sclk && !sclk_p) cap = {cap[NB-2:0], sdout};
        if (done) begin words.push_back(cap); busyc.push_back(nb); syncc.push_back(ns); end
        sclk_p = sclk;
        busy_p = busy;
      end
    end

    function automatic longint getv(input int sel, input int i);
      if (sel == 0) return (i < words.size()) ? longint'(words[i]) : -1;
      if (sel == 1) return (i < busyc.size()) ? longint'(busyc[i]) : -1;
      return (i < syncc.size()) ? longint'(syncc[i]) : -1;
    endfunction

    task automatic tk(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic pulse();
      cnvst = 1'b0;
      tk(1);
      cnvst = 1'b1;
    endtask

    initial begin : p_stim
      logic [NB-1:0] v, v2;
      tk(3);
      chk("reset_outputs", longint'({busy, sclk, sync, sdout, done, ovr}), 0);
      rst = 1'b0;
      tk(2);
      case (gi)
        0: begin
          sample = NB'(32'h2A5A5);
          pulse(); tk(L + 2);
          chk("c0_word0", getv(0, 0), 64'h2A5A5);
          chk("c0_busy_len", getv(1, 0), 40);
          chk("c0_sync_len", getv(2, 0), 72);
          v = NB'($urandom);
          sample = v;
          pulse(); tk(9);
          pulse();
          sample = ~v; mode = 1'b1;
          tk(L);
          chk("c0_overrun_set", longint'(ovr), 1);
          chk("c0_word_during_overrun", getv(0, 1), longint'(v));
          clr = 1'b1; tk(1); clr = 1'b0;
          chk("c0_overrun_clr", longint'(ovr), 0);
          pulse(); tk(CV + 10 * DV);
          cs = 1'b1; tk(1);
          chk("c0_abort_outputs", longint'({busy, sclk, sync, sdout, done}), 0);
          tk(2); cs = 1'b0; tk(2);
          pulse(); tk(L + 2);
          chk("c0_frames_after_abort", longint'(words.size()), 3);
          chk("c0_ramp_after_abort", getv(0, 2), 2);
          pulse(); tk(19);
          rst = 1'b1; cnvst = 1'b0; tk(1);
          chk("c0_rst_outputs", longint'({busy, sclk, sync, sdout, done, ovr}), 0);
          rst = 1'b0; tk(10);
          chk("c0_no_conv_low_release", longint'(busy), 0);
          cnvst = 1'b1; tk(2);
          pulse(); tk(L + 2);
          chk("c0_ramp_after_rst", getv(0, 3), 0);
        end
        1: begin
          v = NB'($urandom); v2 = NB'($urandom);
          sample = v;
          pulse(); tk(L - 1);
          chk("c1_done_pulse", longint'(done), 1);
          tk(1);
          sample = v2;
          pulse();
          chk("c1_b2b_accepted", longint'({busy, ovr}), 64'h2);
          tk(L - 1);
          pulse();
          chk("c1_edge_in_done_ovr", longint'({busy, ovr}), 64'h1);
          tk(3);
          chk("c1_frames", longint'(words.size()), 2);
          chk("c1_word0", getv(0, 0), longint'(v));
          chk("c1_word1", getv(0, 1), longint'(v2));
          chk("c1_sync_len", getv(2, 0), 36);
          chk("c1_busy_len", getv(1, 0), 1);
        end
        default: begin
          mode = 1'b1;
          for (int i = 0; i < 17; i++) begin
            pulse(); tk(L + 2);
          end
          for (int i = 0; i < 17; i++) chk("c2_ramp_wrap", getv(0, i), i % 16);
        end
      endcase
      for (int c = 0; c < 2500; c++) begin
        cnvst  = ($urandom_range(0, L / 2) == 0) ? 1'b0 : 1'b1;
        cs     = ($urandom_range(0, 299) == 0);
        clr    = ($urandom_range(0, 29) == 0);
        rst    = ($urandom_range(0, 999) == 0);
        mode   = 1'($urandom);
        sample = NB'($urandom);
        tk(1);
      end
      rst = 1'b0; cs = 1'b0; cnvst = 1'b1; clr = 1'b0;
      tk(2);
      n_fin++;
    end
  end

  initial begin : p_main
    int guard;
    guard = 0;
    while (n_fin < 3 && guard < 60000) begin
      @(posedge clk);
      guard++;
    end
    chk("all_sequences_finished", longint'(n_fin), 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_serial_emulator.md
ADC_SERIAL_EMULATOR -- requirements
Module: adc_serial_emulator

Interface
REQ-001 Parameter NBITS, default 18, sample word width and number of bits shifted per frame.
REQ-002 Parameter CONV_CYCLES, default 40, BUSY-high duration in CLK cycles; legal range 1..1023.
REQ-003 Parameter SCLK_DIV, default 2, SCLK half-period in CLK cycles; legal range 1..255.
REQ-004 CLK  input  1  sole clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 CS  input  1  chip select, active-low; high forces idle outputs.
REQ-007 CNVST  input  1  convert start, active-low; falling edge starts a conversion.
REQ-008 MODE  input  1  data source: 0 = SAMPLE port, 1 = internal ramp.
REQ-009 SAMPLE  input  NBITS  external sample value.
REQ-010 CLR_OVR  input  1  clears OVERRUN when high for one cycle.
REQ-011 BUSY  output  1  high while conversion in progress.
REQ-012 SCLK  output  1  serial clock, idle low.
REQ-013 SYNC  output  1  high for whole data frame.
REQ-014 SDOUT  output  1  serial data, MSB first.
REQ-015 DONE  output  1  one-cycle pulse at frame completion.
REQ-016 OVERRUN  output  1  sticky flag, conversion request ignored.

Function
REQ-017 CNVST shall be registered once; falling edge = registered value 1, current value 0, detected in cycle t.
REQ-018 States IDLE, CONV, SHIFT; only IDLE accepts a falling edge.
REQ-019 IDLE: edge at t with CS=0 -> latch word (SAMPLE if MODE=0, ramp counter if MODE=1), BUSY=1 from t+1, enter CONV.
REQ-020 IDLE: edge with CS=1 -> ignored, no OVERRUN.
REQ-021 CONV: BUSY high exactly CONV_CYCLES cycles; next cycle BUSY=0, SYNC=1, SDOUT=latched MSB, SCLK=0, enter SHIFT.
REQ-022 SHIFT: SCLK toggles every SCLK_DIV cycles, first toggle low->high; NBITS rising edges per frame.
REQ-023 SDOUT shall change only coincident with SCLK falling edges, stable SCLK_DIV cycles around each rising edge; bit k (MSB first) valid at rising edge k.
REQ-024 SYNC high exactly 2*NBITS*SCLK_DIV cycles; on the final SCLK falling edge SYNC=0, SDOUT=0, DONE=1 for that one cycle, return IDLE.
REQ-025 Ramp counter NBITS wide, increments by 1 on each DONE only, wraps all-ones -> 0.
REQ-026 Falling edge in CONV or SHIFT, including the DONE cycle -> ignored, OVERRUN=1 next cycle, frame unaffected.
REQ-027 CLR_OVR and new overrun in same cycle -> OVERRUN stays 1 (set wins).
REQ-028 CS rising to 1 during CONV or SHIFT -> abort next cycle: BUSY, SCLK, SYNC, SDOUT = 0, IDLE, no DONE, ramp unchanged.
REQ-029 SAMPLE and MODE changes after latching shall not alter the frame in progress.
REQ-030 Back-to-back: edge detected the cycle after DONE shall be accepted normally.

Reset
REQ-031 RST=1: state IDLE; BUSY, SCLK, SYNC, SDOUT, DONE, OVERRUN = 0; ramp = 0; CNVST register = 1.
REQ-032 RST mid-frame shall abort immediately with the above values; no DONE, no partial bits after release.
REQ-033 First CNVST low after RST release without a preceding high sample shall not start a conversion.

Verification
REQ-034 Defaults, MODE=0, SAMPLE=0x2A5A5, CS=0, CNVST 1->0 at t -> BUSY t+1..t+40, SYNC 72 cycles, 18 SCLK rises capture 0x2A5A5, DONE one cycle.
REQ-035 MODE=1, three conversions from reset -> captured words 0, 1, 2; force ramp 0x3FFFF -> next word 0x3FFFF, following 0x00000.
REQ-036 Second CNVST edge at BUSY cycle 10 -> OVERRUN=1, frame data unchanged; CLR_OVR pulse -> OVERRUN=0.
REQ-037 CS to 1 at SHIFT bit 5 -> all outputs 0 next cycle, no DONE, next MODE=1 word equals pre-abort ramp value.
REQ-038 RST at CONV cycle 20 -> all outputs 0 next cycle; CNVST held low through release -> no conversion until a 1->0 edge.
REQ-039 SCLK_DIV=1, CONV_CYCLES=1 -> SYNC 36 cycles, SCLK toggles every cycle, data correct, edge on cycle after DONE accepted.
